out_port_fifo: RTL
==================

Name: out_port_fifo

Overview:
Output-side capture stage that sits directly downstream of the processor top and consumes its 16-bit dout bus. The processor has no write strobe, so this block detects every change of dout, pushes the new value into a small FIFO, and presents the buffered words to a consumer (UART/host model) over a valid/ready interface. Overflow is counted and flagged so the bench can check that no result was lost.

Parameters:
WIDTH, 16, data width; matches processor dout.
DEPTH, 8, FIFO entries; power of two.
AW, 3, pointer width, log2(DEPTH).

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
dout_in  input  WIDTH  processor dout bus.
cap_en  input  1  capture enable; 0 suppresses pushes, but change tracking continues.
out_data  output  WIDTH  head-of-FIFO word; valid only while out_valid=1.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts the head word this cycle.
count  output  AW+1  number of stored words, 0..DEPTH.
full  output  1  count==DEPTH.
overflow  output  1  sticky; set on the first dropped word.
drop_cnt  output  8  dropped-word count; saturates at 255.

Behaviour:
- Reset, sampled on a rising edge with reset=1:
  - last_val=0, rd_ptr=0, wr_ptr=0, count=0.
  - out_valid=0, full=0, overflow=0, drop_cnt=0, out_data=0.
  - FIFO contents are don't-care.
- Reset mid-operation discards all stored words. Outputs take their reset values on the edge where reset=1.
- Change detect:
  - last_val <= dout_in every non-reset cycle, regardless of cap_en.
  - push_req = cap_en && (dout_in != last_val), evaluated combinationally in the current cycle.
  - After reset, last_val=0, so the first nonzero dout_in produces a push. A value of 0 after reset does not.
- Pop: pop = out_valid && out_ready. The consumer may hold out_ready high continuously.
- Push accepted when push_req && (!full || pop). The word is written at wr_ptr and wr_ptr increments.
- Push dropped when push_req && full && !pop:
  - FIFO is unchanged.
  - overflow <= 1; it stays set until reset.
  - drop_cnt increments, saturating at 255.
- Pointers increment modulo DEPTH, so wrap from DEPTH-1 to 0 is natural.
- count update per cycle:
  - +1 on accepted push with no pop.
  - -1 on pop with no push.
  - Unchanged on both or neither.
- Simultaneous push and pop:
  - When full: both take effect, count stays DEPTH, no drop.
  - When empty: out_valid=0, so no pop occurs; push only.
- Latency: there is no bypass. A word pushed on edge N appears on out_data with out_valid=1 after edge N. This is one cycle after dout_in changed, since detection is combinational in the cycle the change is present.
- out_data = mem[rd_ptr], a read of registered storage. It is stable while out_valid=1 and out_ready=0, and it advances after each pop edge.
- full and out_valid are derived from count; count and out_valid are updated on the same edge.
- Ordering is strict FIFO, and every accepted word is delivered exactly once.

Test Plan:
- Reset, then dout_in 0x0000 -> 0x1234 with cap_en=1 and out_ready=0 -> one cycle later out_valid=1, out_data=0x1234, count=1. Holding dout_in at 0x1234 causes no further push.
- cap_en=0 while dout_in steps 0x0001, 0x0002; then cap_en=1 with dout_in held at 0x0002 -> no push. A later change to 0x0003 pushes only 0x0003.
- out_ready=0; apply 10 distinct values 0x0010..0x0019, one per cycle -> count=8, full=1, overflow=1, drop_cnt=2. Then draining with out_ready=1 yields 0x0010..0x0017 in order, and out_valid=0 after the 8th pop.
- FIFO full, out_ready=1, new value 0x00AA arriving in the same cycle -> no drop, count stays 8, drop_cnt unchanged, and 0x00AA is later delivered last.
- out_ready=1 continuously with 20 values at one change per cycle -> all 20 delivered in order, with pointers wrapping twice, count never above 1, and overflow=0.
- Reset asserted with count=5 and overflow=1 -> on the next edge count=0, out_valid=0, overflow=0, drop_cnt=0. A subsequent 0x0000 -> 0x0055 change pushes normally.

Source files
------------

// File: rtl/out_port_fifo.sv
// rtl/out_port_fifo.sv - change-detecting capture FIFO for the processor dout bus
module out_port_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dout_in,
  input  logic             cap_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_val;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  logic push_req;
  logic pop;
  logic push_ok;
  logic push_drop;

  // Status flags come straight from the occupancy count so they move together.
  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_C);

  // The processor has no write strobe: any change of dout is a new word.
  assign push_req  = cap_en && (dout_in != last_val);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok   = push_req && (!full || pop);
  assign push_drop = push_req && full && !pop;

  // Storage contents are meaningless when empty; present zero instead.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Change tracking runs regardless of cap_en so re-enabling does not
  // capture a stale value.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_val <= '0;
    end else begin
      last_val <= dout_in;
    end
  end

  // Storage array; no reset needed since unread slots are never observed.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= dout_in;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // Loss accounting: sticky flag plus a saturating drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (push_drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule
